// File: rtl/instr_fetch_unit.sv
// Instruction fetch master: drives pc into instruction memory, registers the returned word, hands it to decode via valid/ready.
// Start-to-first-valid is 2 edges, then 1 instr/cycle; a held (unaccepted) instruction freezes pc and the register.
module instr_fetch_unit #(
  parameter int                ADDR_W      = 4,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [DATA_W-1:0] HALT_OPCODE = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  output logic              halt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_instr_pc;
  logic [DATA_W-1:0] r_instr;
  logic              r_instr_valid;

  logic w_accept;
  logic w_stall;
  logic w_is_halt;

  assign w_accept  = r_instr_valid & instr_ready;
  assign w_stall   = r_instr_valid & ~instr_ready;
  assign w_is_halt = (imem_data == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pc <= RESET_PC;
          if (start) r_state <= S_RUN;
        end
        S_RUN: begin
          if (redirect) begin
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
          end else if (!w_stall) begin
            r_instr       <= imem_data;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            // pc stays on the halt word so a later restart/redirect sees where we stopped
            if (w_is_halt) r_state <= S_DRAIN;
            else           r_pc    <= r_pc + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          if (redirect) begin
            r_pc          <= redirect_pc;
            r_instr_valid <= 1'b0;
            r_state       <= S_RUN;
          end else if (w_accept) begin
            r_instr_valid <= 1'b0;
            r_state       <= S_HALTED;
          end
        end
        S_HALTED: begin
          r_instr_valid <= 1'b0;
          if (start) begin
            r_pc    <= RESET_PC;
            r_state <= S_RUN;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign halt        = (r_state == S_HALTED);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations plus randomized traffic vs. a behavioural model.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [3:0] pc;
  logic [7:0] imem_data;
  logic [7:0] instr;
  logic [3:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready = 1'b1;
  logic       redirect = 1'b0;
  logic [3:0] redirect_pc = 4'd0;
  logic       busy;
  logic       halt;

  logic [7:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch_unit #(.ADDR_W(4), .DATA_W(8), .RESET_PC(4'd0), .HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy), .halt(halt)
  );

  always #5 clk = ~clk;
  assign imem_data = mem[pc];

  // Behavioural model: mode names as ints, addresses as plain integers modulo 16.
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_HALTED = 3;
  int m_mode  = M_IDLE;
  int m_pc    = 0;
  int m_instr = 0;
  int m_ipc   = 0;
  int m_valid = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= M_IDLE; m_pc <= 0; m_instr <= 0; m_ipc <= 0; m_valid <= 0;
    end else if (m_mode == M_IDLE) begin
      if (start) m_mode <= M_RUN;
    end else if (m_mode == M_HALTED) begin
      if (start) begin m_mode <= M_RUN; m_pc <= 0; end
    end else if (redirect) begin
      m_pc <= int'(redirect_pc); m_valid <= 0; m_mode <= M_RUN;
    end else if (m_mode == M_DRAIN) begin
      if (instr_ready) begin m_valid <= 0; m_mode <= M_HALTED; end
    end else if (m_valid == 0 || instr_ready) begin
      m_instr <= int'(mem[m_pc]);
      m_ipc   <= m_pc;
      m_valid <= 1;
      if (mem[m_pc] == 8'hFF) m_mode <= M_DRAIN;
      else                    m_pc   <= (m_pc + 1) % 16;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Packed view: {pc, instr, instr_pc, valid, busy, halt}
  function automatic logic [31:0] dut_vec();
    return {13'd0, pc, instr, instr_pc, instr_valid, busy, halt};
  endfunction

  function automatic logic [31:0] vec(input int p, input int i, input int ip, input int v, input int b, input int h);
    logic [3:0] p4, ip4;
    logic [7:0] i8;
    p4 = p[3:0]; ip4 = ip[3:0]; i8 = i[7:0];
    return {13'd0, p4, i8, ip4, v[0], b[0], h[0]};
  endfunction

  always @(negedge clk) begin
    chk("model", dut_vec(),
        vec(m_pc, m_instr, m_ipc, m_valid,
            (m_mode == M_RUN || m_mode == M_DRAIN) ? 1 : 0, (m_mode == M_HALTED) ? 1 : 0));
  end

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic restart();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);

    #1 rst_n = 1'b0;
    #2;
    chk("reset_values", dut_vec(), vec(0, 0, 0, 0, 0, 0));
    cyc();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("idle_hold", dut_vec(), vec(0, 0, 0, 0, 0, 0));
    end

    // Streaming with wrap
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_e0", dut_vec(), vec(0, 0, 0, 0, 1, 0));
    cyc();
    chk("stream_0", dut_vec(), vec(1, 0, 0, 1, 1, 0));
    for (int k = 1; k <= 16; k++) begin
      cyc();
      chk("stream", dut_vec(), vec((k + 1) % 16, k % 16, k % 16, 1, 1, 0));
    end

    // Backpressure
    restart();
    cyc(3);
    chk("bp_pre", dut_vec(), vec(4, 3, 3, 1, 1, 0));
    instr_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("bp_hold", dut_vec(), vec(4, 3, 3, 1, 1, 0));
    end
    instr_ready = 1'b1;
    cyc();
    chk("bp_release", dut_vec(), vec(5, 4, 4, 1, 1, 0));

    // Redirect flush, then redirect during stall
    restart();
    cyc(2);
    chk("rd_pre", dut_vec(), vec(3, 2, 2, 1, 1, 0));
    redirect = 1'b1; redirect_pc = 4'd10;
    cyc();
    redirect = 1'b0;
    chk("rd_flush", dut_vec(), vec(10, 2, 2, 0, 1, 0));
    cyc();
    chk("rd_target", dut_vec(), vec(11, 8'h0A, 10, 1, 1, 0));
    instr_ready = 1'b0;
    cyc();
    chk("rd_stall", dut_vec(), vec(11, 8'h0A, 10, 1, 1, 0));
    redirect = 1'b1; redirect_pc = 4'd3;
    cyc();
    redirect = 1'b0; instr_ready = 1'b1;
    chk("rd_stall_flush", dut_vec(), vec(3, 8'h0A, 10, 0, 1, 0));
    cyc();
    chk("rd_stall_target", dut_vec(), vec(4, 3, 3, 1, 1, 0));

    // Halt / drain / restart
    mem[5] = 8'hFF;
    restart();
    cyc(5);
    chk("halt_deliver", dut_vec(), vec(5, 8'hFF, 5, 1, 1, 0));
    instr_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("drain_hold", dut_vec(), vec(5, 8'hFF, 5, 1, 1, 0));
    end
    instr_ready = 1'b1;
    cyc();
    chk("halted", dut_vec(), vec(5, 8'hFF, 5, 0, 0, 1));
    cyc(2);
    chk("halted_frozen", dut_vec(), vec(5, 8'hFF, 5, 0, 0, 1));
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_e0", dut_vec(), vec(0, 8'hFF, 5, 0, 1, 0));
    cyc();
    chk("restart_first", dut_vec(), vec(1, 0, 0, 1, 1, 0));
    mem[5] = 8'h05;

    // Async reset between edges
    cyc(3);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset", dut_vec(), vec(0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("post_reset_fetch", dut_vec(), vec(1, 0, 0, 1, 1, 0));

    // Randomized traffic against the model
    for (int i = 0; i < 16; i++) mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
    for (int k = 0; k < 3000; k++) begin
      start       = ($urandom_range(0, 19) == 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = 4'($urandom);
      if ($urandom_range(0, 31) == 0) mem[$urandom_range(0, 15)] = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      cyc();
    end

    start = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
